echo_delay: RTL and testbench



---
 rtl/echo_delay.sv | 120 ++++++++++++
 tb/tb_echo_delay.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/echo_delay.sv
// Echo / delay effect: a DELAY-sample circular buffer whose attenuated output is
// mixed back into the dry input. Each accepted sample takes three clocks
// (IDLE -> READ -> MIX) to pass through the single-port buffer RAM.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for in_ready; on strobe latch sample, issue buffer read
// READ  | RAM read in flight; delayed sample valid on next cycle
// MIX   | mix/saturate, write buffer, register output, advance pointer
module echo_delay #(
  parameter int DELAY       = 4800,
  parameter int ADDR_WIDTH  = 13,
  parameter int ATTEN_SHIFT = 1,
  parameter bit FEEDBACK    = 1'b1
) (
  input  logic               clk_sys,
  input  logic               rst_b,
  input  logic signed [15:0] sample_in,
  input  logic               in_ready,
  input  logic               echo_en,
  output logic signed [15:0] sample_out,
  output logic               out_valid,
  output logic               overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    MIX  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DELAY - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic                    filled;
  logic signed [15:0]      sample_lat;
  logic signed [15:0]      ram_q;
  logic signed [15:0]      mem [0:DELAY-1];

  logic                    ram_re;
  logic                    ram_we;
  logic signed [15:0]      delayed;
  logic signed [15:0]      delayed_att;
  logic signed [16:0]      mix_wide;
  logic signed [15:0]      mix_sat;
  logic signed [15:0]      wr_data;

  // State register.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and RAM strobes; in_ready outside IDLE never changes the sequence.
  always_comb begin
    state_nxt = state;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    case (state)
      IDLE: begin
        if (in_ready) begin
          ram_re    = 1'b1;
          state_nxt = READ;
        end
      end
      READ: state_nxt = MIX;
      MIX: begin
        ram_we    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Mix path: until the buffer has wrapped once its contents are stale, so the
  // delayed term is forced to zero.
  always_comb begin
    delayed     = filled ? ram_q : 16'sd0;
    delayed_att = delayed >>> ATTEN_SHIFT;
    mix_wide    = {sample_lat[15], sample_lat} + {delayed_att[15], delayed_att};
    mix_sat     = mix_wide[15:0];
    if (mix_wide[16] != mix_wide[15])
      mix_sat = mix_wide[16] ? -16'sd32768 : 16'sd32767;
    wr_data     = FEEDBACK ? mix_sat : sample_lat;
  end

  // Buffer RAM: single port, read in IDLE and write in MIX never collide.
  always_ff @(posedge clk_sys) begin
    if (ram_we) mem[wr_ptr] <= wr_data;
    if (ram_re) ram_q <= mem[wr_ptr];
  end

  // Datapath registers, pointer and status flags.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr     <= '0;
      filled     <= 1'b0;
      sample_lat <= 16'sd0;
      sample_out <= 16'sd0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_ready && state != IDLE) overrun <= 1'b1;
      if (state == IDLE && in_ready) sample_lat <= sample_in;
      if (state == MIX) begin
        sample_out <= echo_en ? mix_sat : sample_lat;
        out_valid  <= 1'b1;
        if (wr_ptr == LAST_PTR) begin
          wr_ptr <= '0;
          filled <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_echo_delay.sv
// Directed bench for echo_delay: two instances (feedback and single-echo) share
// stimulus; a vector table covers impulse, saturation and echo_en cases, and
// hand-written sequences cover overrun and mid-sample reset.
module tb_echo_delay;

  logic               clk_sys = 1'b0;
  logic               rst_b   = 1'b0;
  logic signed [15:0] sample_in = 16'sd0;
  logic               in_ready  = 1'b0;
  logic               echo_en   = 1'b0;

  logic signed [15:0] out_fb, out_nf;
  logic               vld_fb, vld_nf;
  logic               ovr_fb, ovr_nf;

  int passed = 0;
  int total  = 0;
  int vcnt_fb = 0;

  always #5 clk_sys = ~clk_sys;

  echo_delay #(.DELAY(4), .ADDR_WIDTH(2), .ATTEN_SHIFT(1), .FEEDBACK(1'b1)) dut_fb (
    .clk_sys(clk_sys), .rst_b(rst_b), .sample_in(sample_in), .in_ready(in_ready),
    .echo_en(echo_en), .sample_out(out_fb), .out_valid(vld_fb), .overrun(ovr_fb));

  echo_delay #(.DELAY(4), .ADDR_WIDTH(2), .ATTEN_SHIFT(1), .FEEDBACK(1'b0)) dut_nf (
    .clk_sys(clk_sys), .rst_b(rst_b), .sample_in(sample_in), .in_ready(in_ready),
    .echo_en(echo_en), .sample_out(out_nf), .out_valid(vld_nf), .overrun(ovr_nf));

  always @(negedge clk_sys) if (vld_fb) vcnt_fb++;

  typedef struct {
    bit                 rst;
    logic signed [15:0] din;
    bit                 en;
    logic signed [15:0] exp_fb;
    logic signed [15:0] exp_nf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input bit r, input int d, input bit e, input int f, input int n);
    vec_t v;
    v.rst = r; v.din = 16'(d); v.en = e; v.exp_fb = 16'(f); v.exp_nf = 16'(n);
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst_b = 1'b0;
    in_ready = 1'b0;
    @(negedge clk_sys);
    rst_b = 1'b1;
  endtask

  // One sample through both instances; outputs checked at the 3rd edge only.
  task automatic send(input logic signed [15:0] d, input bit e, input string tag,
                      output logic signed [15:0] o_fb, output logic signed [15:0] o_nf);
    @(negedge clk_sys);
    sample_in = d; echo_en = e; in_ready = 1'b1;
    @(negedge clk_sys);
    in_ready = 1'b0;
    chk({tag, " valid_read_fb"}, int'(vld_fb), 0);
    @(negedge clk_sys);
    chk({tag, " valid_mix_nf"}, int'(vld_nf), 0);
    @(negedge clk_sys);
    chk({tag, " valid_fb"}, int'(vld_fb), 1);
    chk({tag, " valid_nf"}, int'(vld_nf), 1);
    o_fb = out_fb;
    o_nf = out_nf;
  endtask

  initial begin
    logic signed [15:0] ofb, onf;
    int c0;

    // impulse, feedback vs single echo
    add(1, 16000, 1, 16000, 16000);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0);
    add(0, 0, 1, 8000, 8000);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0);
    add(0, 0, 1, 4000, 0);
    // positive saturation
    for (int i = 0; i < 4; i++) add(i == 0, 30000, 1, 30000, 30000);
    for (int i = 0; i < 4; i++) add(0, 30000, 1, 32767, 32767);
    // negative saturation
    for (int i = 0; i < 8; i++) add(i == 0, -32768, 1, -32768, -32768);
    // echo disabled while the buffer keeps filling
    add(1, 16000, 0, 16000, 16000);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0);
    add(0, 0, 1, 8000, 8000);
    // negative delayed term, arithmetic shift
    add(1, -1001, 1, -1001, -1001);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0);
    add(0, 100, 1, -401, -401);

    do_reset();
    chk("reset sample_out", int'(out_fb), 0);
    chk("reset out_valid", int'(vld_fb), 0);
    chk("reset overrun", int'(ovr_fb), 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      send(vecs[i].din, vecs[i].en, $sformatf("vec%0d", i), ofb, onf);
      chk($sformatf("vec%0d out_fb", i), int'(ofb), int'(vecs[i].exp_fb));
      chk($sformatf("vec%0d out_nf", i), int'(onf), int'(vecs[i].exp_nf));
    end

    // back-to-back strobes: only the first accepted, overrun sticky
    do_reset();
    @(negedge clk_sys);
    c0 = vcnt_fb;
    sample_in = 16'sd1000; echo_en = 1'b1; in_ready = 1'b1;
    @(negedge clk_sys);
    sample_in = 16'sd5555;
    @(negedge clk_sys);
    @(negedge clk_sys);
    in_ready = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk_sys);
    chk("overrun valid count", vcnt_fb - c0, 1);
    chk("overrun sample", int'(out_fb), 1000);
    chk("overrun flag fb", int'(ovr_fb), 1);
    chk("overrun flag nf", int'(ovr_nf), 1);
    send(16'sd0, 1'b1, "post_ovr", ofb, onf);
    chk("overrun sticky", int'(ovr_fb), 1);
    do_reset();
    chk("overrun cleared", int'(ovr_fb), 0);

    // reset while in READ aborts the sample and clears filled
    for (int i = 0; i < 4; i++) send(16'sd20000, 1'b1, "fill", ofb, onf);
    chk("fill out", int'(ofb), 20000);
    @(negedge clk_sys);
    sample_in = 16'sd7; in_ready = 1'b1;
    @(negedge clk_sys);
    in_ready = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("midreset out_fb", int'(out_fb), 0);
    chk("midreset out_nf", int'(out_nf), 0);
    c0 = vcnt_fb;
    for (int i = 0; i < 3; i++) @(negedge clk_sys);
    chk("midreset no valid", vcnt_fb - c0, 0);
    rst_b = 1'b1;
    for (int i = 0; i < 2; i++) @(negedge clk_sys);
    chk("midreset release no valid", vcnt_fb - c0, 0);
    send(16'sd1234, 1'b1, "after_reset", ofb, onf);
    chk("after_reset out_fb", int'(ofb), 1234);
    chk("after_reset out_nf", int'(onf), 1234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
